// File: rtl/video_ddr_pkg.sv
// Shared types and helpers for the video-to-DDR write scheduler.
// Holds the scheduler state encoding, request length and buffer rotation.
package video_ddr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sched_state_t;

    function automatic logic [15:0] req_len_bytes(input int img_width, input int bytes_per_pix);
        return 16'(img_width * bytes_per_pix);
    endfunction

    // Next buffer to write, stepping over the one the reader is displaying.
    // With only two buffers there is nowhere to step to, so writing stays put.
    function automatic logic [1:0] next_buf_idx(input logic [1:0] cur,
                                                input logic [1:0] rd,
                                                input int         num_buf);
        int nxt;
        nxt = (int'(cur) + 1) % num_buf;
        if (nxt == int'(rd)) begin
            if (num_buf == 2) nxt = int'(cur);
            else              nxt = (nxt + 1) % num_buf;
        end
        return 2'(nxt);
    endfunction

endpackage

// File: rtl/video_wr_frame_sched_if.sv
// Line write request channel from the video-domain scheduler to the CDC/AXI burst logic.
interface video_wr_frame_sched_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [15:0]           req_len;

    modport master (output req_valid, req_addr, req_len, input req_ready);
    modport slave  (input req_valid, req_addr, req_len, output req_ready);
endinterface

// File: rtl/sync_req_fifo.sv
// Single-clock FIFO with full/empty/count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_req_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define
    // validity, so stale contents are never observed as live entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/video_wr_frame_sched.sv
// Tracks video frame/line timing and queues one DDR write request per good
// active line, addressed into a rotating frame store that avoids the read buffer.
module video_wr_frame_sched
    import video_ddr_pkg::*;
#(
    parameter int                    IMG_WIDTH     = 640,
    parameter int                    IMG_HEIGHT    = 480,
    parameter int                    BYTES_PER_PIX = 4,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE  = 32'h0020_0000,
    parameter int                    NUM_BUF       = 3,
    parameter int                    REQ_DEPTH     = 4,
    parameter bit                    VS_POL        = 1'b1
) (
    input  logic                      video_clk,
    input  logic                      video_rst_n,
    input  logic                      enable,
    input  logic                      video_vs,
    input  logic                      video_de,
    input  logic [1:0]                rd_buf_idx,
    video_wr_frame_sched_if.master    req_if,
    output logic [1:0]                wr_buf_idx,
    output logic [11:0]               line_cnt,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      overflow
);
    localparam int          LINE_BYTES = IMG_WIDTH * BYTES_PER_PIX;
    localparam logic [15:0] REQ_LEN    = req_len_bytes(IMG_WIDTH, BYTES_PER_PIX);
    localparam int          CW         = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;

    sched_state_t          state_q, state_d;
    logic                  vs_d1, de_d1;
    logic [11:0]           pix_cnt_q, pix_cnt_d;
    logic [11:0]           line_cnt_d;
    logic [1:0]            buf_d;
    logic                  err_q, err_d;
    logic                  done_d, ferr_d;
    logic                  push, drop, pop;
    logic                  vs_start, line_end;
    logic [ADDR_WIDTH-1:0] push_addr, head_addr;
    logic                  fifo_full, fifo_empty;
    logic [CW:0]           unused_fifo_count;

    assign vs_start  = (vs_d1 != VS_POL) && (video_vs == VS_POL);
    assign line_end  = de_d1 & ~video_de;
    assign push_addr = FRAME_BASE
                     + ADDR_WIDTH'(wr_buf_idx) * FRAME_STRIDE
                     + ADDR_WIDTH'(line_cnt) * ADDR_WIDTH'(LINE_BYTES);

    assign pop              = req_if.req_valid & req_if.req_ready;
    assign req_if.req_valid = ~fifo_empty;
    // Address and length read as zero while nothing is queued, so the channel is all-zero out of reset.
    assign req_if.req_addr  = fifo_empty ? '0 : head_addr;
    assign req_if.req_len   = fifo_empty ? '0 : REQ_LEN;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt;
        buf_d      = wr_buf_idx;
        err_d      = err_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_start && enable) begin
                    state_d    = ACTIVE;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_start) begin
                    if (line_cnt == 12'(IMG_HEIGHT) && !err_q) begin
                        done_d = 1'b1;
                        buf_d  = next_buf_idx(wr_buf_idx, rd_buf_idx, NUM_BUF);
                    end else begin
                        ferr_d = 1'b1;
                    end
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = enable ? ACTIVE : IDLE;
                end else if (line_end) begin
                    pix_cnt_d = '0;
                    if (pix_cnt_q != 12'(IMG_WIDTH) || line_cnt >= 12'(IMG_HEIGHT)) begin
                        err_d = 1'b1;
                    end else begin
                        push       = 1'b1;
                        line_cnt_d = line_cnt + 1'b1;
                        // A full queue with no pop this cycle loses the line and spoils the frame.
                        if (fifo_full && !pop) begin
                            drop  = 1'b1;
                            err_d = 1'b1;
                        end
                    end
                end else if (video_de && pix_cnt_q != 12'hFFF) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state_q    <= IDLE;
            vs_d1      <= 1'b0;
            de_d1      <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt   <= '0;
            wr_buf_idx <= '0;
            err_q      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_d1      <= video_vs;
            de_d1      <= video_de;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt   <= line_cnt_d;
            wr_buf_idx <= buf_d;
            err_q      <= err_d;
            frame_done <= done_d;
            frame_err  <= ferr_d;
            overflow   <= overflow | drop;
        end
    end

    sync_req_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (video_clk),
        .rst_n (video_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_addr),
        .rdata (head_addr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

endmodule

// File: tb/tb_video_wr_frame_sched.sv
// Directed bench for video_wr_frame_sched: 8x4 frames, three buffers, reader on buffer 2;
// expected request addresses are queued as lines are driven and matched on each handshake.
module tb_video_wr_frame_sched;

    localparam int          W      = 8;
    localparam int          H      = 4;
    localparam logic [31:0] STRIDE = 32'h0020_0000;

    logic        video_clk   = 1'b0;
    logic        video_rst_n = 1'b0;
    logic        enable      = 1'b0;
    logic        video_vs    = 1'b0;
    logic        video_de    = 1'b0;
    logic [1:0]  rd_buf_idx  = 2'd2;
    logic [1:0]  wr_buf_idx;
    logic [11:0] line_cnt;
    logic        frame_done, frame_err, overflow;

    video_wr_frame_sched_if #(.ADDR_WIDTH(32)) bus ();

    video_wr_frame_sched #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .BYTES_PER_PIX (4),
        .ADDR_WIDTH    (32),
        .FRAME_BASE    (32'h0),
        .FRAME_STRIDE  (STRIDE),
        .NUM_BUF       (3),
        .REQ_DEPTH     (4),
        .VS_POL        (1'b1)
    ) dut (
        .video_clk   (video_clk),
        .video_rst_n (video_rst_n),
        .enable      (enable),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .rd_buf_idx  (rd_buf_idx),
        .req_if      (bus.master),
        .wr_buf_idx  (wr_buf_idx),
        .line_cnt    (line_cnt),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 video_clk = ~video_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_err   = 0;
    int          n_pop   = 0;
    int          m_buf   = 0;
    int          m_line  = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reader sits on buffer 2, so with three buffers writing alternates 0 and 1.
    function automatic int tb_next(input int b);
        int n;
        n = (b + 1) % 3;
        if (n == 2) n = (n + 1) % 3;
        return n;
    endfunction

    // One clock: observe outputs at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [31:0] exp_addr;
        @(negedge video_clk);
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (bus.req_valid && bus.req_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("req_unexpected_valid", 32'(bus.req_valid), 32'd0);
            end else begin
                exp_addr = exp_q.pop_front();
                check("req_addr", bus.req_addr, exp_addr);
                check("req_len", 32'(bus.req_len), 32'(W * 4));
            end
        end
        @(posedge video_clk);
        #1;
    endtask

    task automatic send_line(input int npix, input bit exp_push);
        if (exp_push) begin
            exp_q.push_back(32'(m_buf) * STRIDE + 32'(m_line) * 32'(W * 4));
            m_line++;
        end
        video_de = 1'b1;
        repeat (npix) tick();
        video_de = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vs_pulse();
        video_vs = 1'b1;
        repeat (2) tick();
        video_vs = 1'b0;
        repeat (2) tick();
        m_line = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_pop, snap_done, snap_err;
        bus.req_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_req_addr", bus.req_addr, 32'd0);
        check("rst_req_len", 32'(bus.req_len), 32'd0);
        check("rst_wr_buf_idx", 32'(wr_buf_idx), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_flags", {29'd0, frame_done, frame_err, overflow}, 32'd0);
        video_rst_n = 1'b1;
        tick();

        // Nominal frames
        enable        = 1'b1;
        bus.req_ready = 1'b1;
        vs_pulse();
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < H; l++) send_line(W, 1'b1);
            check("nominal_line_cnt", 32'(line_cnt), 32'(H));
            vs_pulse();
            m_buf = tb_next(m_buf);
            check("nominal_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));
        end
        check("nominal_done_count", n_done, 3);
        check("nominal_err_count", n_err, 0);
        check("nominal_pops", n_pop, 3 * H);
        check("nominal_drained", exp_q.size(), 0);

        // Short line: no request for it, frame_err, buffer held
        send_line(W, 1'b1);
        send_line(W, 1'b1);
        send_line(W - 1, 1'b0);
        send_line(W, 1'b1);
        check("short_line_cnt", 32'(line_cnt), 32'd3);
        vs_pulse();
        check("short_err_count", n_err, 1);
        check("short_done_count", n_done, 3);
        check("short_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));
        check("short_drained", exp_q.size(), 0);

        // Fill the queue, then push and pop together while full
        bus.req_ready = 1'b0;
        snap_pop = n_pop;
        for (int l = 0; l < H; l++) send_line(W, 1'b1);
        check("full_req_valid", 32'(bus.req_valid), 32'd1);
        check("full_no_pops", n_pop, snap_pop);
        vs_pulse();
        m_buf = tb_next(m_buf);
        check("full_done_count", n_done, 4);
        check("full_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));
        exp_q.push_back(32'(m_buf) * STRIDE);
        m_line = 1;
        video_de = 1'b1;
        repeat (W) tick();
        video_de      = 1'b0;
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        repeat (2) tick();
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_pops", n_pop, snap_pop + 1);
        check("pushpop_held", exp_q.size(), 4);
        bus.req_ready = 1'b1;
        repeat (6) tick();
        check("pushpop_drain_pops", n_pop, snap_pop + 5);
        check("pushpop_drained", exp_q.size(), 0);
        for (int l = 1; l < H; l++) send_line(W, 1'b1);
        vs_pulse();
        m_buf = tb_next(m_buf);
        check("pushpop_done_count", n_done, 5);

        // Enable dropped during line 1: frame still completes, then idle
        send_line(W, 1'b1);
        exp_q.push_back(32'(m_buf) * STRIDE + 32'(m_line) * 32'(W * 4));
        m_line++;
        video_de = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        repeat (W - 3) tick();
        video_de = 1'b0;
        repeat (3) tick();
        for (int l = 2; l < H; l++) send_line(W, 1'b1);
        vs_pulse();
        m_buf = tb_next(m_buf);
        check("endrop_done_count", n_done, 6);
        check("endrop_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));
        snap_pop  = n_pop;
        snap_done = n_done;
        snap_err  = n_err;
        for (int l = 0; l < H; l++) send_line(W, 1'b0);
        enable = 1'b1;
        vs_pulse();
        check("idle_no_requests", n_pop, snap_pop);
        check("idle_no_done", n_done, snap_done);
        check("idle_no_err", n_err, snap_err);
        check("idle_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));

        // Overflow: fill the queue, then a stalled frame whose lines are all dropped
        bus.req_ready = 1'b0;
        for (int l = 0; l < H; l++) send_line(W, 1'b1);
        vs_pulse();
        m_buf = tb_next(m_buf);
        check("ovf_fill_done_count", n_done, 7);
        snap_pop = n_pop;
        snap_err = n_err;
        send_line(W, 1'b0);
        check("ovf_sticky_set", 32'(overflow), 32'd1);
        for (int l = 1; l < H; l++) send_line(W, 1'b0);
        check("ovf_line_cnt", 32'(line_cnt), 32'(H));
        vs_pulse();
        check("ovf_frame_err", n_err, snap_err + 1);
        check("ovf_done_count", n_done, 7);
        check("ovf_wr_buf_idx", 32'(wr_buf_idx), 32'(m_buf));
        check("ovf_held_valid", 32'(bus.req_valid), 32'd1);
        check("ovf_no_pops", n_pop, snap_pop);
        bus.req_ready = 1'b1;
        repeat (8) tick();
        check("ovf_drain_pops", n_pop, snap_pop + 4);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_still_set", 32'(overflow), 32'd1);

        // Reset in the middle of an active line
        bus.req_ready = 1'b0;
        send_line(W, 1'b1);
        video_de = 1'b1;
        repeat (3) tick();
        video_rst_n = 1'b0;
        #1;
        check("midrst_req_valid", 32'(bus.req_valid), 32'd0);
        check("midrst_req_addr", bus.req_addr, 32'd0);
        check("midrst_req_len", 32'(bus.req_len), 32'd0);
        check("midrst_wr_buf_idx", 32'(wr_buf_idx), 32'd0);
        check("midrst_line_cnt", 32'(line_cnt), 32'd0);
        check("midrst_flags", {29'd0, frame_done, frame_err, overflow}, 32'd0);
        exp_q.delete();
        m_buf  = 0;
        m_line = 0;
        video_de = 1'b0;
        repeat (2) tick();
        video_rst_n   = 1'b1;
        bus.req_ready = 1'b1;
        tick();
        snap_pop = n_pop;
        send_line(W, 1'b0);
        send_line(W, 1'b0);
        check("postrst_no_requests", n_pop, snap_pop);
        vs_pulse();
        send_line(W, 1'b1);
        check("postrst_first_request", n_pop, snap_pop + 1);
        check("postrst_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
